// File: rtl/lane_status_scanner.sv
// lane_status_scanner: snapshots a lane vector and streams asserted lane indices, then reports group popcounts
// Ports: clk, rst_n (sync, active-low); lanes_i capture source; sample_i capture request;
// out_valid/out_ready/out_idx/out_group index stream; cnt_lo/cnt_hi group popcounts;
// done end-of-scan pulse; busy scan in progress; overrun saturating ignored-request count.
// Optional LANE_SCAN_MASK_EN adds mask_i, clearing masked lanes at capture.
module lane_status_scanner #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 10,
    localparam int IW = $clog2(WIDTH),
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lanes_i,
`ifdef LANE_SCAN_MASK_EN
    input  logic [WIDTH-1:0] mask_i,
`endif
    input  logic             sample_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic             out_group,
    output logic [CW-1:0]    cnt_lo,
    output logic [CW-1:0]    cnt_hi,
    output logic             done,
    output logic             busy,
    output logic [7:0]       overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] snap, cap, rest;
    logic [CW-1:0] pc_lo, pc_hi;
`ifdef LANE_SCAN_MASK_EN
    assign cap = lanes_i & ~mask_i;
`else
    assign cap = lanes_i;
`endif
    // snap holds only the lanes not yet reported; rest drops the one being reported now
    assign rest = snap & (snap - WIDTH'(1));
    assign out_group = int'(out_idx) >= SPLIT;
    always_comb begin
        out_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (snap[i]) out_idx = IW'(i);
    end
    always_comb begin
        pc_lo = '0;
        pc_hi = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i < SPLIT) pc_lo = pc_lo + CW'(cap[i]);
            else pc_hi = pc_hi + CW'(cap[i]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            out_valid <= 1'b0;
            cnt_lo    <= '0;
            cnt_hi    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && sample_i && overrun != 8'hFF) overrun <= overrun + 8'd1;
            case (state)
                IDLE: if (sample_i) begin
                    snap      <= cap;
                    cnt_lo    <= pc_lo;
                    cnt_hi    <= pc_hi;
                    busy      <= 1'b1;
                    out_valid <= cap != '0;
                    done      <= cap == '0;
                    state     <= cap != '0 ? SCAN : DONE;
                end
                SCAN: if (out_ready) begin
                    snap <= rest;
                    if (rest == '0) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lane_status_scanner.sv
// tb_lane_status_scanner: randomized self-checking bench against a queue-based reference of the lane scan
module tb_lane_status_scanner;
    localparam int SPLIT = 10;
    logic clk = 0, rst_n = 0, sample_i = 0, out_ready = 0;
    logic [15:0] lanes_i = '0, mask_i = '0;
    logic out_valid, out_group, done, busy;
    logic [3:0] out_idx;
    logic [4:0] cnt_lo, cnt_hi;
    logic [7:0] overrun;
    int n_cmp = 0, n_bad = 0, exp_ovr = 0;
    always #5 clk = ~clk;
    lane_status_scanner dut (
        .clk(clk), .rst_n(rst_n), .lanes_i(lanes_i),
`ifdef LANE_SCAN_MASK_EN
        .mask_i(mask_i),
`endif
        .sample_i(sample_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_group(out_group), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi),
        .done(done), .busy(busy), .overrun(overrun)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // rmode: 1 ready always, 2 toggling from 0, 3 random, 4 one accept every 20 cycles
    task automatic run_scan(input logic [15:0] v, input int rmode, input bit hold);
        int q[$];
        int guard;
        logic [15:0] eff;
        eff = v & ~mask_i;
        q = {};
        for (int i = 0; i < 16; i++) if (eff[i]) q.push_back(i);
        @(negedge clk);
        lanes_i = v; sample_i = 1; out_ready = 1'($urandom);
        guard = 0;
        forever begin
            @(negedge clk);
            lanes_i = 16'($urandom);
            chk("overrun", overrun, exp_ovr);
            if (q.size() > 0) begin
                chk("valid", out_valid, 1);
                chk("idx", out_idx, q[0]);
                chk("group", out_group, q[0] >= SPLIT);
                chk("busy", busy, 1);
                chk("done_low", done, 0);
                out_ready = rmode == 1 ? 1'b1 : rmode == 2 ? 1'(guard % 2) :
                            rmode == 3 ? 1'($urandom) : 1'(guard % 20 == 19);
                sample_i = hold;
                if (hold && exp_ovr < 255) exp_ovr++;
                if (out_ready) void'(q.pop_front());
            end else begin
                chk("done", done, 1);
                chk("valid_in_done", out_valid, 0);
                chk("busy_in_done", busy, 1);
                sample_i = 0;
                break;
            end
            if (++guard > 1000) begin
                chk("scan_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("cnt_lo", cnt_lo, $countones(eff[SPLIT-1:0]));
        chk("cnt_hi", cnt_hi, $countones(eff[15:SPLIT]));
        chk("overrun_end", overrun, exp_ovr);
    endtask
    task automatic chk_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_group", out_group, 0);
        chk("rst_cnt_lo", cnt_lo, 0);
        chk("rst_cnt_hi", cnt_hi, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
    endtask
    initial begin
        repeat (2) begin
            @(negedge clk);
            lanes_i = 16'($urandom); sample_i = 1'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        chk_reset();
        rst_n = 1; sample_i = 0;
        run_scan(16'hFFFF, 1, 0);
        run_scan(16'h0000, 3, 0);
        run_scan(16'h8401, 2, 0);
        for (int n = 0; n < 20; n++)
            run_scan(16'($urandom) & 16'($urandom), $urandom_range(1, 3), 1'($urandom));
        repeat (3) run_scan(16'hFFFF, 4, 1);
        chk("overrun_saturated", overrun, 255);
        @(negedge clk);
        lanes_i = 16'hFFFF; sample_i = 1; out_ready = 0;
        @(negedge clk);
        sample_i = 0;
        chk("mid_valid", out_valid, 1);
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk_reset();
        rst_n = 1; exp_ovr = 0;
        run_scan(16'h0F0F, 1, 0);
`ifdef LANE_SCAN_MASK_EN
        mask_i = 16'h03FF;
        run_scan(16'hFFFF, 1, 0);
        mask_i = 16'h0000;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
